weight_fetch_ctrl: RTL
======================

Name: weight_fetch_ctrl

Overview:
Read-side master for weight_buffer. It accepts a fetch command (base address, word count, repeat count) and issues rd_en/rd_addr to the buffer. It absorbs the buffer's fixed 2-cycle read latency and streams 128-bit weight words to the PE array over a valid/ready interface. Reads are credit-limited into a small output FIFO, so PE backpressure never drops a word.

Parameters:
DATA_WIDTH, 128, weight word width; matches weight_buffer.
ADDR_WIDTH, 14, buffer word address width (256 KB / 16 B).
LEN_WIDTH, 15, width of word count (max 16384).
REP_WIDTH, 8, width of repeat count.
RD_LATENCY, 2, cycles from buf_rd_en to buf_rd_valid.
FIFO_DEPTH, 4, output FIFO entries; must be >= RD_LATENCY+1.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_base_addr  in  ADDR_WIDTH  first word address
cmd_num_words  in  LEN_WIDTH  words per pass
cmd_repeat  in  REP_WIDTH  extra passes; total passes = cmd_repeat+1
buf_wr_active  in  1  DMA writing buffer this cycle; read must not issue
buf_rd_en  out  1  buffer read strobe
buf_rd_addr  out  ADDR_WIDTH  buffer read address
buf_rd_data  in  DATA_WIDTH  buffer read data
buf_rd_valid  in  1  buffer read data valid
w_valid  out  1  weight word valid to PE array
w_ready  in  1  PE array accepts word
w_data  out  DATA_WIDTH  weight word
w_last  out  1  last word of current pass
busy  out  1  not IDLE
done  out  1  one-cycle pulse when a command completes

Behaviour:
- Clock is clk. Reset rst is synchronous, active-high. On reset: state IDLE, all counters 0, FIFO empty, cmd_ready=1, buf_rd_en=0, buf_rd_addr=0, w_valid=0, w_last=0, w_data=0, busy=0, done=0. Reset mid-command discards in-flight reads; buf_rd_valid data arriving after reset is ignored.
- States are IDLE, FETCH and DRAIN.
- IDLE:
  - On cmd_valid&cmd_ready, latch the command.
  - If cmd_num_words==0: pulse done the next cycle and stay in IDLE.
  - Otherwise go to FETCH.
- FETCH:
  - Issue condition: buf_rd_en = !buf_wr_active && (outstanding + fifo_count) < FIFO_DEPTH.
  - outstanding counts reads issued but not yet returned.
  - Address is base + word_idx, wrapping modulo 2^ADDR_WIDTH.
  - Issuing the last word of a pass with passes remaining: word_idx resets to 0 and the next cycle reads base (no bubble).
  - Issuing the last word of the last pass: go to DRAIN.
- DRAIN: no issue. When outstanding==0, FIFO empty, and the final word has been accepted: pulse done and go to IDLE.
- Return path: buf_rd_valid pushes buf_rd_data into the FIFO. The credit rule guarantees no overflow; overflow is an assertion error. The outstanding counter handles issue and return in the same cycle (net 0).
- Output:
  - w_valid = FIFO not empty; w_data = FIFO head.
  - Pop on w_valid&w_ready.
  - While w_valid is high and w_ready is low, w_data and w_last are held stable.
- w_last: an output word counter counts accepted words. w_last is high when out_idx == num_words-1; the counter wraps to 0 each pass.
- Throughput: 1 word/cycle sustained when w_ready=1 and buf_wr_active=0. First w_valid appears RD_LATENCY+1 cycles after command acceptance.
- buf_wr_active high stalls issue only; the return path and output continue.
- done is issued exactly once per command. A new command is accepted no earlier than the cycle after done.

Decomposition:
- npu_pkg additions:
  - WB_DATA_WIDTH, WB_ADDR_WIDTH, WB_RD_LATENCY constants.
  - weight_fetch_cmd_t struct (base_addr, num_words, repeat).
  - wf_state_e enum (IDLE, FETCH, DRAIN).
- One sub-module: sync_fifo (DATA_WIDTH x FIFO_DEPTH, first-word-fall-through, count output) for the return buffer.

Test Plan:
- Single pass with w_ready=1: base=0x010, num=8, rep=0 -> addresses 0x010..0x017 issued on consecutive cycles; 8 words in order; w_last on word 8 only; done 1 cycle after word 8 is accepted.
- Repeat: base=0x100, num=3, rep=2 -> 9 words in address order 100,101,102 repeated 3 times; w_last on words 3, 6, 9; single done pulse.
- Backpressure: num=16 with w_ready toggling 1-in-3 -> outstanding+fifo_count never exceeds 4; no lost or duplicated words; w_data stable while stalled.
- Wrap and write conflict: base=0x3FFE, num=4 -> addresses 3FFE,3FFF,0000,0001. With buf_wr_active high for 2 cycles mid-stream -> no buf_rd_en in those cycles; output order preserved.
- Zero length: cmd_num_words=0 -> no buf_rd_en; done 1 cycle after acceptance; cmd_ready high again the next cycle.
- Reset mid-FETCH with 2 reads outstanding -> next cycle all outputs at reset values; late buf_rd_valid is ignored; a fresh command (num=2) completes correctly.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared NPU constants and types used by the weight buffer read-side master.
package npu_pkg;

  localparam int WB_DATA_WIDTH = 128;
  localparam int WB_ADDR_WIDTH = 14;
  localparam int WB_RD_LATENCY = 2;
  localparam int WF_LEN_WIDTH  = 15;
  localparam int WF_REP_WIDTH  = 8;

  typedef struct packed {
    logic [WB_ADDR_WIDTH-1:0] base_addr;
    logic [WF_LEN_WIDTH-1:0]  num_words;
    logic [WF_REP_WIDTH-1:0]  rep;
  } weight_fetch_cmd_t;

  typedef enum logic [1:0] {
    WF_IDLE  = 2'd0,
    WF_FETCH = 2'd1,
    WF_DRAIN = 2'd2
  } wf_state_e;

endpackage

// File: rtl/weight_fetch_ctrl_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
module sync_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
    end
  end

  // Storage needs no reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push_i && full_o && !pop_i)) else $error("sync_fifo overflow");
    end
  end

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Weight buffer read master: credit-limited reads, fixed-latency return into a
// small FIFO, and a valid/ready stream of weight words to the PE array.
module weight_fetch_ctrl
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int LEN_WIDTH  = WF_LEN_WIDTH,
  parameter int REP_WIDTH  = WF_REP_WIDTH,
  parameter int RD_LATENCY = WB_RD_LATENCY,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_base_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_num_words,
  input  logic [REP_WIDTH-1:0]  cmd_repeat,
  input  logic                  buf_wr_active,
  output logic                  buf_rd_en,
  output logic [ADDR_WIDTH-1:0] buf_rd_addr,
  input  logic [DATA_WIDTH-1:0] buf_rd_data,
  input  logic                  buf_rd_valid,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_last,
  output logic                  busy,
  output logic                  done
);

  // Handshake rule for cmd_* and w_*: a transfer happens on a rising clk edge
  // where valid and ready are both high; valid-side payload holds until then.

  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  wf_state_e         state_q, state_d;
  weight_fetch_cmd_t cmd_q, cmd_d;
  logic [LEN_WIDTH-1:0]  word_idx_q, word_idx_d;
  logic [LEN_WIDTH-1:0]  out_idx_q, out_idx_d;
  logic [REP_WIDTH-1:0]  pass_q, pass_d;
  logic [CNT_W-1:0]      outstanding_q, outstanding_d;
  logic [RD_LATENCY-1:0] issue_pipe_q, issue_pipe_d;
  logic                  zero_done_q, zero_done_d;

  logic                  accept, credit_ok, rd_en, ret_ok, pop;
  logic                  last_word, last_pass, out_last, drain_ok;
  logic [CNT_W:0]        credit_sum;
  logic                  fifo_empty, fifo_full;
  logic [CNT_W-1:0]      fifo_count;
  logic [DATA_WIDTH-1:0] fifo_data;

  assign accept     = cmd_valid && cmd_ready;
  assign credit_sum = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign credit_ok  = credit_sum < (CNT_W+1)'(FIFO_DEPTH);
  assign rd_en      = (state_q == WF_FETCH) && !buf_wr_active && credit_ok;
  assign last_word  = (word_idx_q == cmd_q.num_words - LEN_WIDTH'(1));
  assign last_pass  = (pass_q == cmd_q.rep);
  // Only returns that match one of our own issues are accepted, so data still
  // in flight from before a reset is dropped.
  assign ret_ok     = buf_rd_valid && issue_pipe_q[RD_LATENCY-1];
  assign pop        = w_valid && w_ready;
  assign out_last   = (out_idx_q == cmd_q.num_words - LEN_WIDTH'(1));
  assign drain_ok   = (outstanding_q == '0) && fifo_empty;

  assign cmd_ready   = (state_q == WF_IDLE) && !zero_done_q;
  assign busy        = (state_q != WF_IDLE);
  assign buf_rd_en   = rd_en;
  assign buf_rd_addr = rd_en ? (cmd_q.base_addr + word_idx_q[ADDR_WIDTH-1:0]) : '0;
  assign w_valid     = !fifo_empty;
  assign w_data      = fifo_empty ? '0 : fifo_data;
  assign w_last      = !fifo_empty && out_last;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    word_idx_d  = word_idx_q;
    pass_d      = pass_q;
    zero_done_d = 1'b0;
    done        = zero_done_q;
    unique case (state_q)
      WF_IDLE: begin
        if (accept) begin
          cmd_d      = '{base_addr: cmd_base_addr, num_words: cmd_num_words, rep: cmd_repeat};
          word_idx_d = '0;
          pass_d     = '0;
          if (cmd_num_words == '0) zero_done_d = 1'b1;
          else                     state_d     = WF_FETCH;
        end
      end
      WF_FETCH: begin
        if (rd_en) begin
          if (last_word) begin
            word_idx_d = '0;
            if (last_pass) state_d = WF_DRAIN;
            else           pass_d  = pass_q + REP_WIDTH'(1);
          end else begin
            word_idx_d = word_idx_q + LEN_WIDTH'(1);
          end
        end
      end
      WF_DRAIN: begin
        if (drain_ok) begin
          done    = 1'b1;
          state_d = WF_IDLE;
        end
      end
      default: state_d = WF_IDLE;
    endcase
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (rd_en && !ret_ok)      outstanding_d = outstanding_q + CNT_W'(1);
    else if (!rd_en && ret_ok) outstanding_d = outstanding_q - CNT_W'(1);

    out_idx_d = out_idx_q;
    if (accept)   out_idx_d = '0;
    else if (pop) out_idx_d = out_last ? '0 : out_idx_q + LEN_WIDTH'(1);

    issue_pipe_d = '0;
    issue_pipe_d[0] = rd_en;
    for (int i = 1; i < RD_LATENCY; i++) issue_pipe_d[i] = issue_pipe_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= WF_IDLE;
      cmd_q         <= '0;
      word_idx_q    <= '0;
      out_idx_q     <= '0;
      pass_q        <= '0;
      outstanding_q <= '0;
      issue_pipe_q  <= '0;
      zero_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      word_idx_q    <= word_idx_d;
      out_idx_q     <= out_idx_d;
      pass_q        <= pass_d;
      outstanding_q <= outstanding_d;
      issue_pipe_q  <= issue_pipe_d;
      zero_done_q   <= zero_done_d;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_ret_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (ret_ok),
    .data_i  (buf_rd_data),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  logic unused_full;
  assign unused_full = fifo_full;

endmodule
